// File: rtl/cache_pkg.sv
// Shared cache geometry, miss-controller state encoding and line address composition.
package cache_pkg;

    localparam int unsigned INDEX_W    = 8;
    localparam int unsigned TAG_W      = 20;
    localparam int unsigned LINE_WORDS = 8;
    localparam int unsigned OFFSET_W   = 5;
    localparam int unsigned WORD_W     = $clog2(LINE_WORDS);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWbReq,
        StRdReq,
        StRefill,
        StDone
    } miss_state_e;

    // {tag, index, zero offset} is one bit wider than the bus; the tag MSB falls off the top.
    function automatic logic [31:0] line_addr(logic [TAG_W-1:0] tag, logic [INDEX_W-1:0] index);
        return 32'({tag, index, {OFFSET_W{1'b0}}});
    endfunction

endpackage

// File: rtl/dcache_miss_ctrl_if.sv
// Miss-controller signal bundle: lookup request, dirty regfile, AXI bridge and data-bank refill.
interface dcache_miss_ctrl_if import cache_pkg::*; ();

    logic                     miss_valid;
    logic                     miss_ready;
    logic [INDEX_W-1:0]       miss_index;
    logic [TAG_W-1:0]         miss_tag;
    logic                     miss_is_store;
    logic                     victim_valid;
    logic [TAG_W-1:0]         victim_tag;
    logic [32*LINE_WORDS-1:0] victim_data;

    logic [INDEX_W-1:0]       dirty_rd_addr;
    logic                     dirty_dout;
    logic [INDEX_W-1:0]       dirty_wr_addr;
    logic                     dirty_en;
    logic                     dirty_din;

    logic                     wr_req;
    logic [31:0]              wr_addr;
    logic [32*LINE_WORDS-1:0] wr_data;
    logic                     wr_rdy;
    logic                     rd_req;
    logic [31:0]              rd_addr;
    logic                     rd_rdy;
    logic                     ret_valid;
    logic                     ret_last;
    logic [31:0]              ret_data;

    logic                     refill_we;
    logic [WORD_W-1:0]        refill_word;
    logic [31:0]              refill_data;
    logic                     fill_done;

    // Controller side.
    modport master (
        input  miss_valid, miss_index, miss_tag, miss_is_store,
        input  victim_valid, victim_tag, victim_data,
        input  dirty_dout, wr_rdy, rd_rdy, ret_valid, ret_last, ret_data,
        output miss_ready, dirty_rd_addr, dirty_wr_addr, dirty_en, dirty_din,
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output refill_we, refill_word, refill_data, fill_done
    );

    // Surrounding cache, regfile and bridge side.
    modport slave (
        output miss_valid, miss_index, miss_tag, miss_is_store,
        output victim_valid, victim_tag, victim_data,
        output dirty_dout, wr_rdy, rd_rdy, ret_valid, ret_last, ret_data,
        input  miss_ready, dirty_rd_addr, dirty_wr_addr, dirty_en, dirty_din,
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  refill_we, refill_word, refill_data, fill_done
    );

endinterface

// File: rtl/refill_beat_cnt.sv
// Refill beat counter: clear has priority, increment wraps modulo Words.
module refill_beat_cnt #(
    parameter int unsigned Words = 8,
    parameter int unsigned Width = $clog2(Words)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = (cnt_q == Width'(Words - 1)) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Direct-mapped dcache miss handler: optional dirty writeback, line refill, dirty-bit update.
module dcache_miss_ctrl import cache_pkg::*; (
    input logic               clk,
    input logic               resetn,
    dcache_miss_ctrl_if.master bus
);

    miss_state_e        state_q, state_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               is_store_q, is_store_d;

    logic               miss_ready;
    logic               wr_req;
    logic               rd_req;
    logic               refill_we;
    logic               fill_done;
    logic               dirty_en;
    logic               cnt_clr;
    logic               cnt_inc;
    logic [WORD_W-1:0]  beat_cnt;

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        tag_d      = tag_q;
        is_store_d = is_store_q;
        miss_ready = 1'b0;
        wr_req     = 1'b0;
        rd_req     = 1'b0;
        refill_we  = 1'b0;
        fill_done  = 1'b0;
        dirty_en   = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;

        unique case (state_q)
            StIdle: begin
                miss_ready = 1'b1;
                if (bus.miss_valid) begin
                    index_d    = bus.miss_index;
                    tag_d      = bus.miss_tag;
                    is_store_d = bus.miss_is_store;
                    state_d    = StLookup;
                end
            end
            StLookup: begin
                // Only a line that is both resident and modified needs to go back to memory.
                state_d = (bus.dirty_dout && bus.victim_valid) ? StWbReq : StRdReq;
            end
            StWbReq: begin
                wr_req = 1'b1;
                if (bus.wr_rdy) begin
                    state_d = StRdReq;
                end
            end
            StRdReq: begin
                rd_req = 1'b1;
                if (bus.rd_rdy) begin
                    cnt_clr = 1'b1;
                    state_d = StRefill;
                end
            end
            StRefill: begin
                if (bus.ret_valid) begin
                    refill_we = 1'b1;
                    cnt_inc   = 1'b1;
                    if (bus.ret_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                fill_done = 1'b1;
                dirty_en  = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            index_q    <= '0;
            tag_q      <= '0;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            tag_q      <= tag_d;
            is_store_q <= is_store_d;
        end
    end

    refill_beat_cnt #(
        .Words (LINE_WORDS)
    ) u_beat_cnt (
        .clk_i  (clk),
        .rst_ni (resetn),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .cnt_o  (beat_cnt)
    );

    assign bus.miss_ready    = miss_ready;
    assign bus.dirty_rd_addr = index_q;
    assign bus.dirty_wr_addr = index_q;
    assign bus.dirty_en      = dirty_en;
    assign bus.dirty_din     = is_store_q;
    assign bus.wr_req        = wr_req;
    assign bus.wr_addr       = line_addr(bus.victim_tag, index_q);
    assign bus.wr_data       = bus.victim_data;
    assign bus.rd_req        = rd_req;
    assign bus.rd_addr       = line_addr(tag_q, index_q);
    assign bus.refill_we     = refill_we;
    assign bus.refill_word   = beat_cnt;
    assign bus.refill_data   = bus.ret_data;
    assign bus.fill_done     = fill_done;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl with a behavioural dirty regfile and scripted bridge.
module tb_dcache_miss_ctrl;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    dcache_miss_ctrl_if bus ();

    dcache_miss_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Dirty regfile model with write-to-read bypass.
    bit [255:0]  dirty_mem;
    logic        pre_en;
    logic [7:0]  pre_addr;
    logic        pre_val;

    always @(posedge clk) begin
        if (bus.dirty_en) dirty_mem[bus.dirty_wr_addr] <= bus.dirty_din;
        else if (pre_en) dirty_mem[pre_addr] <= pre_val;
    end

    always_comb begin
        bus.dirty_dout = dirty_mem[bus.dirty_rd_addr];
        if (bus.dirty_en && bus.dirty_wr_addr == bus.dirty_rd_addr) bus.dirty_dout = bus.dirty_din;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic preset_dirty(input logic [7:0] idx, input logic val);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = idx; pre_val = val;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // One full miss transaction; abort_beat >= 0 pulls reset during that refill beat.
    task automatic run_miss(input logic [7:0] idx, input logic [19:0] tag, input logic st,
                            input logic vv, input logic [19:0] vtag, input int dirty_init,
                            input int wr_delay, input logic [31:0] mask, input logic exp_wb,
                            input logic [31:0] exp_wa, input int abort_beat);
        logic [255:0] vdata;
        logic [31:0]  exp_ra;
        int beat;
        int cyc;
        logic v;
        vdata  = {8{24'hDA7A00, idx}};
        exp_ra = (32'(tag) << 13) | (32'(idx) << 5);
        if (dirty_init >= 0) preset_dirty(idx, dirty_init[0]);

        @(negedge clk);
        bus.miss_valid = 1'b1; bus.miss_index = idx; bus.miss_tag = tag;
        bus.miss_is_store = st; bus.victim_valid = vv; bus.victim_tag = vtag;
        bus.victim_data = vdata;
        #1 chk1("idle_ready", bus.miss_ready, 1'b1);
        @(posedge clk);

        @(negedge clk);
        bus.miss_valid = 1'b0;
        #1;
        chk1("lookup_ready", bus.miss_ready, 1'b0);
        chkw("lookup_rd_addr", 256'(bus.dirty_rd_addr), 256'(idx));
        chk1("lookup_wr_req", bus.wr_req, 1'b0);
        chk1("lookup_rd_req", bus.rd_req, 1'b0);
        @(posedge clk);

        if (exp_wb) begin
            for (int d = 0; d <= wr_delay; d++) begin
                @(negedge clk);
                bus.wr_rdy = (d == wr_delay);
                #1;
                chk1("wb_wr_req", bus.wr_req, 1'b1);
                chk1("wb_no_rd_req", bus.rd_req, 1'b0);
                chkw("wb_wr_addr", 256'(bus.wr_addr), 256'(exp_wa));
                chkw("wb_wr_data", bus.wr_data, vdata);
                @(posedge clk);
            end
        end

        @(negedge clk);
        bus.wr_rdy = 1'b0; bus.rd_rdy = 1'b1;
        #1;
        chk1("rd_req", bus.rd_req, 1'b1);
        chk1("rd_no_wr_req", bus.wr_req, 1'b0);
        chkw("rd_addr", 256'(bus.rd_addr), 256'(exp_ra));
        @(posedge clk);

        beat = 0;
        cyc  = 0;
        while (beat < 8 && cyc < 64) begin
            @(negedge clk);
            bus.rd_rdy = 1'b0;
            v = (cyc >= 32) || mask[cyc[4:0]];
            bus.ret_valid = v;
            bus.ret_last  = v && (beat == 7);
            bus.ret_data  = v ? 32'(32'h100 + beat) : 32'hBAD0_BAD0;
            #1;
            chk1("refill_we", bus.refill_we, v);
            chk1("refill_no_done", bus.fill_done, 1'b0);
            chk1("refill_no_dirty_en", bus.dirty_en, 1'b0);
            if (v) begin
                chkw("refill_word", 256'(bus.refill_word), 256'(beat));
                chkw("refill_data", 256'(bus.refill_data), 256'(32'h100 + beat));
            end
            if (beat == abort_beat) begin
                #1 resetn = 1'b0;
                #1;
                chk1("rst_rd_req", bus.rd_req, 1'b0);
                chk1("rst_refill_we", bus.refill_we, 1'b0);
                chk1("rst_dirty_en", bus.dirty_en, 1'b0);
                chk1("rst_ready", bus.miss_ready, 1'b1);
                @(negedge clk);
                bus.ret_valid = 1'b0; bus.ret_last = 1'b0;
                resetn = 1'b1;
                return;
            end
            @(posedge clk);
            if (v) beat++;
            cyc++;
        end
        total++;
        if (beat != 8) begin
            bad++;
            $display("FAIL refill_timeout: got %0d beats want 8", beat);
        end

        @(negedge clk);
        bus.ret_valid = 1'b0; bus.ret_last = 1'b0;
        #1;
        chk1("done_fill_done", bus.fill_done, 1'b1);
        chk1("done_dirty_en", bus.dirty_en, 1'b1);
        chk1("done_dirty_din", bus.dirty_din, st);
        chkw("done_dirty_wr_addr", 256'(bus.dirty_wr_addr), 256'(idx));
        @(posedge clk);

        @(negedge clk);
        #1;
        chk1("after_ready", bus.miss_ready, 1'b1);
        chk1("after_fill_done", bus.fill_done, 1'b0);
        chk1("after_dirty_en", bus.dirty_en, 1'b0);
    endtask

    typedef struct {
        logic [7:0]  idx;
        logic [19:0] tag;
        logic        st;
        logic        vv;
        logic [19:0] vtag;
        int          dirty_init;
        int          wr_delay;
        logic [31:0] mask;
        logic        exp_wb;
        logic [31:0] exp_wa;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'h12, 20'h11111, 1'b0, 1'b1, 20'h22222, 0, 0, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vecs[1] = '{8'h34, 20'h12345, 1'b0, 1'b1, 20'hABCDE, 1, 3, 32'hFFFF_FFFF, 1'b1,
                    32'h579B_C680};
        vecs[2] = '{8'h78, 20'h0F0F0, 1'b1, 1'b0, 20'h33333, 1, 0, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vecs[3] = '{8'h9A, 20'h55555, 1'b0, 1'b1, 20'h44444, 0, 0, 32'h0000_0F8D, 1'b0, 32'h0};
        vecs[4] = '{8'hFF, 20'hFFFFF, 1'b1, 1'b1, 20'h00001, 1, 0, 32'hFFFF_FFFF, 1'b1,
                    32'h0000_3FE0};

        resetn = 1'b0;
        pre_en = 1'b0; pre_addr = '0; pre_val = 1'b0;
        bus.miss_valid = 1'b0; bus.miss_index = '0; bus.miss_tag = '0; bus.miss_is_store = 1'b0;
        bus.victim_valid = 1'b0; bus.victim_tag = '0; bus.victim_data = '0;
        bus.wr_rdy = 1'b0; bus.rd_rdy = 1'b0;
        bus.ret_valid = 1'b0; bus.ret_last = 1'b0; bus.ret_data = '0;
        repeat (2) @(negedge clk);
        #1;
        chk1("reset_ready", bus.miss_ready, 1'b1);
        chk1("reset_wr_req", bus.wr_req, 1'b0);
        chk1("reset_rd_req", bus.rd_req, 1'b0);
        chk1("reset_dirty_en", bus.dirty_en, 1'b0);
        chk1("reset_fill_done", bus.fill_done, 1'b0);
        chk1("reset_refill_we", bus.refill_we, 1'b0);
        chkw("reset_index", 256'(bus.dirty_rd_addr), 256'(0));
        chkw("reset_refill_word", 256'(bus.refill_word), 256'(0));
        resetn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_miss(vecs[i].idx, vecs[i].tag, vecs[i].st, vecs[i].vv, vecs[i].vtag,
                     vecs[i].dirty_init, vecs[i].wr_delay, vecs[i].mask, vecs[i].exp_wb,
                     vecs[i].exp_wa, -1);
        end

        // Reset mid-refill, then the same miss again runs to completion.
        run_miss(8'hC3, 20'h24680, 1'b0, 1'b1, 20'h13579, 0, 0, 32'hFFFF_FFFF, 1'b0, 32'h0, 3);
        run_miss(8'hC3, 20'h24680, 1'b0, 1'b1, 20'h13579, -1, 0, 32'hFFFF_FFFF, 1'b0, 32'h0, -1);

        // Store then load to the same set: the load sees the bit the store set.
        run_miss(8'h56, 20'h0AAAA, 1'b1, 1'b1, 20'h56565, 0, 0, 32'hFFFF_FFFF, 1'b0, 32'h0, -1);
        run_miss(8'h56, 20'h0BBBB, 1'b0, 1'b1, 20'h77777, -1, 1, 32'hFFFF_FFFF, 1'b1,
                 32'hEEEE_EAC0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
